// File: rtl/shift_reg_universal_if.sv
// Control/data bundle for the universal shift register: the master drives mode and data,
// the slave (the register) returns its contents and status.
interface shift_reg_universal_if #(
  parameter int unsigned WIDTH = 8
);
  logic [1:0]       ch;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic             rotate;
  logic             bounce;
  logic [WIDTH-1:0] q;
  logic             step;
  logic             dir;

  modport master (
    output ch, d, sin, rotate, bounce,
    input  q, step, dir
  );

  modport slave (
    input  ch, d, sin, rotate, bounce,
    output q, step, dir
  );
endinterface

// File: rtl/shift_reg_universal.sv
// Universal shift register with load/hold/shift/rotate, a step prescaler and an
// autonomous bounce mode that reverses direction whenever the lit bit reaches an end.
module shift_reg_universal #(
  parameter int unsigned     WIDTH    = 8,
  parameter int unsigned     PRESCALE = 1,
  parameter logic [WIDTH-1:0] INIT    = 'h01
) (
  input  logic                  clk,
  input  logic                  reset_n,
  shift_reg_universal_if.slave  bus
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {StManual, StBR2L, StBL2R} state_e;

  state_e           st_q, st_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             tick;
  logic             man_in;

  assign tick = (cnt_q == CntW'(PRESCALE - 1));

  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    st_d   = st_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    man_in = bus.rotate ? ((bus.ch == 2'b01) ? q_q[0] : q_q[WIDTH-1]) : bus.sin;

    if (bus.ch == 2'b00) begin
      q_d   = bus.d;
      cnt_d = '0;
      st_d  = StManual;
      dir_d = 1'b0;
    end else if (bus.ch != 2'b11) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (bus.bounce) begin
        // Bounce always shifts in 0; the end test picks the direction for this tick.
        case (st_q)
          StBR2L: begin
            if (tick) begin
              step_d = 1'b1;
              if (q_q[WIDTH-1]) begin
                st_d = StBL2R;
                q_d  = {1'b0, q_q[WIDTH-1:1]};
              end else begin
                q_d  = {q_q[WIDTH-2:0], 1'b0};
              end
            end
          end
          StBL2R: begin
            if (tick) begin
              step_d = 1'b1;
              if (q_q[0]) begin
                st_d = StBR2L;
                q_d  = {q_q[WIDTH-2:0], 1'b0};
              end else begin
                q_d  = {1'b0, q_q[WIDTH-1:1]};
              end
            end
          end
          default: st_d = StBR2L;
        endcase
        dir_d = (st_d == StBL2R);
      end else begin
        st_d = StManual;
        if (tick) begin
          step_d = 1'b1;
          q_d    = (bus.ch == 2'b01) ? {man_in, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], man_in};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q    <= INIT;
      cnt_q  <= '0;
      st_q   <= StManual;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      st_q   <= st_d;
      dir_q  <= dir_d;
      step_q <= step_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.step = step_q;
  assign bus.dir  = dir_q;

endmodule

// File: tb/tb_shift_reg_universal.sv
// Drives two registers (PRESCALE 1 and 4) with directed and random stimulus and compares
// every cycle against an arithmetic model of the shift/bounce rules.
module tb_shift_reg_universal;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  shift_reg_universal_if #(.WIDTH(W)) bus0 ();
  shift_reg_universal_if #(.WIDTH(W)) bus1 ();

  shift_reg_universal #(.WIDTH(W), .PRESCALE(1), .INIT(8'h01)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  shift_reg_universal #(.WIDTH(W), .PRESCALE(4), .INIT(8'h01)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: mode 0 = manual, 1 = bouncing right-to-left, 2 = bouncing left-to-right.
  int ps     [2] = '{1, 4};
  int m_q    [2];
  int m_cnt  [2];
  int m_mode [2];
  int m_dir  [2];
  int m_step [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_q[i] = 1; m_cnt[i] = 0; m_mode[i] = 0; m_dir[i] = 0; m_step[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic [1:0] ch, input logic [7:0] d,
                            input logic sin, input logic rot, input logic bnc);
    int q;
    int nq;
    int in_bit;
    bit tick;
    q         = m_q[i];
    nq        = q;
    tick      = (m_cnt[i] == ps[i] - 1);
    m_step[i] = 0;
    if (ch == 2'd0) begin
      nq = int'(d); m_cnt[i] = 0; m_mode[i] = 0; m_dir[i] = 0;
    end else if (ch != 2'd3) begin
      m_cnt[i] = tick ? 0 : m_cnt[i] + 1;
      if (bnc) begin
        if (m_mode[i] == 0) begin
          m_mode[i] = 1;
        end else if (tick) begin
          m_step[i] = 1;
          if (m_mode[i] == 1 && q >= 128) m_mode[i] = 2;
          else if (m_mode[i] == 2 && (q % 2) == 1) m_mode[i] = 1;
          nq = (m_mode[i] == 2) ? q / 2 : (q * 2) % 256;
        end
        m_dir[i] = (m_mode[i] == 2) ? 1 : 0;
      end else begin
        m_mode[i] = 0;
        if (tick) begin
          m_step[i] = 1;
          if (ch == 2'd1) begin
            in_bit = rot ? q % 2 : int'(sin);
            nq     = q / 2 + in_bit * 128;
          end else begin
            in_bit = rot ? q / 128 : int'(sin);
            nq     = (q * 2) % 256 + in_bit;
          end
        end
      end
    end
    m_q[i] = nq;
  endtask

  task automatic drive(input logic [1:0] ch, input logic [7:0] d, input logic sin,
                       input logic rot, input logic bnc);
    bus0.ch = ch; bus0.d = d; bus0.sin = sin; bus0.rotate = rot; bus0.bounce = bnc;
    bus1.ch = ch; bus1.d = d; bus1.sin = sin; bus1.rotate = rot; bus1.bounce = bnc;
    model_step(0, ch, d, sin, rot, bnc);
    model_step(1, ch, d, sin, rot, bnc);
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("q0",    32'(bus0.q),    32'(m_q[0]));
    chk("step0", 32'(bus0.step), 32'(m_step[0]));
    chk("dir0",  32'(bus0.dir),  32'(m_dir[0]));
    chk("q1",    32'(bus1.q),    32'(m_q[1]));
    chk("step1", 32'(bus1.step), 32'(m_step[1]));
    chk("dir1",  32'(bus1.dir),  32'(m_dir[1]));
  endtask

  // Asynchronous reset asserted between clock edges; outputs must react without a clock.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_q0",    32'(bus0.q),    32'h01);
    chk("rst_step0", 32'(bus0.step), 32'h0);
    chk("rst_q1",    32'(bus1.q),    32'h01);
    chk("rst_dir1",  32'(bus1.dir),  32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [1:0] ch;
    reset_n = 1'b1;
    bus0.ch = 2'b11; bus0.d = '0; bus0.sin = 1'b0; bus0.rotate = 1'b0; bus0.bounce = 1'b0;
    bus1.ch = 2'b11; bus1.d = '0; bus1.sin = 1'b0; bus1.rotate = 1'b0; bus1.bounce = 1'b0;
    #1;
    do_reset();

    // Load then hold for 10 cycles.
    drive(2'b00, 8'hA5, 1'b0, 1'b0, 1'b0); cycle();
    chk("t2_load", 32'(bus0.q), 32'hA5);
    for (int k = 0; k < 10; k++) begin drive(2'b11, 8'h00, 1'b0, 1'b0, 1'b0); cycle(); end
    chk("t2_hold", 32'(bus1.q), 32'hA5);

    // Manual shifts, with and without rotate.
    drive(2'b00, 8'h81, 1'b0, 1'b0, 1'b0); cycle();
    drive(2'b01, 8'h00, 1'b0, 1'b0, 1'b0); cycle();
    chk("t3_lr1", 32'(bus0.q), 32'h40);
    drive(2'b01, 8'h00, 1'b0, 1'b0, 1'b0); cycle();
    chk("t3_lr2", 32'(bus0.q), 32'h20);
    drive(2'b00, 8'h81, 1'b0, 1'b0, 1'b0); cycle();
    drive(2'b10, 8'h00, 1'b0, 1'b1, 1'b0); cycle();
    chk("t3_rot1", 32'(bus0.q), 32'h03);
    drive(2'b10, 8'h00, 1'b0, 1'b1, 1'b0); cycle();
    chk("t3_rot2", 32'(bus0.q), 32'h06);
    drive(2'b00, 8'h80, 1'b0, 1'b0, 1'b0); cycle();
    drive(2'b10, 8'h00, 1'b0, 1'b1, 1'b0); cycle();
    chk("t3_rot_wrap", 32'(bus0.q), 32'h01);

    // Prescaled stepping on dut1.
    drive(2'b00, 8'h01, 1'b0, 1'b0, 1'b0); cycle();
    for (int k = 0; k < 3; k++) begin drive(2'b10, 8'h00, 1'b0, 1'b0, 1'b0); cycle(); end
    chk("t4_wait", 32'(bus1.q), 32'h01);
    drive(2'b10, 8'h00, 1'b0, 1'b0, 1'b0); cycle();
    chk("t4_step_q",  32'(bus1.q),    32'h02);
    chk("t4_step_pl", 32'(bus1.step), 32'h1);

    // Bounce: entry, run to the left end, reverse, run to the right end, reverse.
    drive(2'b00, 8'h01, 1'b0, 1'b0, 1'b0); cycle();
    drive(2'b10, 8'h00, 1'b0, 1'b0, 1'b1); cycle();
    chk("t5_entry",      32'(bus0.q),    32'h01);
    chk("t5_entry_step", 32'(bus0.step), 32'h0);
    for (int k = 0; k < 7; k++) begin drive(2'b10, 8'h00, 1'b0, 1'b0, 1'b1); cycle(); end
    chk("t5_left", 32'(bus0.q), 32'h80);
    drive(2'b10, 8'h00, 1'b0, 1'b0, 1'b1); cycle();
    chk("t5_rev_q",   32'(bus0.q),   32'h40);
    chk("t5_rev_dir", 32'(bus0.dir), 32'h1);
    for (int k = 0; k < 5; k++) begin drive(2'b11, 8'h00, 1'b0, 1'b0, 1'b1); cycle(); end
    chk("t6_hold_q",   32'(bus0.q),   32'h40);
    chk("t6_hold_dir", 32'(bus0.dir), 32'h1);
    for (int k = 0; k < 6; k++) begin drive(2'b10, 8'h00, 1'b0, 1'b0, 1'b1); cycle(); end
    chk("t5_right", 32'(bus0.q), 32'h01);
    drive(2'b10, 8'h00, 1'b0, 1'b0, 1'b1); cycle();
    chk("t5_rev2_q",   32'(bus0.q),   32'h02);
    chk("t5_rev2_dir", 32'(bus0.dir), 32'h0);
    drive(2'b00, 8'h5A, 1'b0, 1'b0, 1'b1); cycle();
    chk("t6_load_q",   32'(bus0.q),   32'h5A);
    chk("t6_load_dir", 32'(bus0.dir), 32'h0);

    // Mid-operation reset, then randomized traffic.
    drive(2'b01, 8'h00, 1'b1, 1'b0, 1'b0); cycle();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(9))
        0:       ch = 2'b00;
        1:       ch = 2'b11;
        2, 3, 4: ch = 2'b01;
        default: ch = 2'b10;
      endcase
      drive(ch, 8'($urandom), 1'($urandom), 1'($urandom_range(3) == 0),
            1'($urandom_range(9) < 4));
      cycle();
      if ($urandom_range(99) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
